// File: rtl/mdc_input_buffer.sv
// Ping-pong frame buffer feeding the first radix-2 stage of the 32-point MDC FFT.
// Natural-order samples are written serially; each frame is read back as N/2 pairs (x[k], x[k+N/2]).
module mdc_input_buffer #(
  parameter int DATA_W = 9,
  parameter int N      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] outUp_re,
  output logic [DATA_W-1:0] outUp_im,
  output logic [DATA_W-1:0] outL_re,
  output logic [DATA_W-1:0] outL_im,
  output logic              out_first,
  output logic              out_last
);

  localparam int AW   = $clog2(N);
  localparam int HALF = N / 2;
  localparam int RW   = AW - 1;
  localparam logic [AW-1:0] WR_LAST = AW'(N - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(HALF - 1);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  logic [DATA_W-1:0] memRe_q [2][N];
  logic [DATA_W-1:0] memIm_q [2][N];

  logic [1:0]        full_q, full_d;
  logic              wrSel_q, wrSel_d;
  logic [AW-1:0]     wrCnt_q, wrCnt_d;
  logic              rdSel_q, rdSel_d;
  logic [RW-1:0]     rdCnt_q, rdCnt_d;
  state_t            state_q, state_d;

  logic              outValid_q, outValid_d;
  logic              outFirst_q, outFirst_d;
  logic              outLast_q, outLast_d;
  logic [DATA_W-1:0] upRe_q, upRe_d;
  logic [DATA_W-1:0] upIm_q, upIm_d;
  logic [DATA_W-1:0] lRe_q, lRe_d;
  logic [DATA_W-1:0] lIm_q, lIm_d;

  logic              wrAccept;
  logic              wrDone;
  logic              rdLoad;
  logic              rdDone;
  logic [AW-1:0]     rdAddrUp;
  logic [AW-1:0]     rdAddrL;

  assign in_ready = !full_q[wrSel_q];
  assign wrAccept = in_valid && in_ready;
  assign wrDone   = wrAccept && (wrCnt_q == WR_LAST);

  // The lower lane is simply the upper address with the MSB set (offset N/2).
  assign rdAddrUp = {1'b0, rdCnt_q};
  assign rdAddrL  = {1'b1, rdCnt_q};
  assign rdLoad   = (state_q == S_READ) && (!outValid_q || out_ready);

  always_ff @(posedge clk) begin
    if (wrAccept) begin
      memRe_q[wrSel_q][wrCnt_q] <= in_re;
      memIm_q[wrSel_q][wrCnt_q] <= in_im;
    end
  end

  always_comb begin
    wrCnt_d = wrCnt_q;
    wrSel_d = wrSel_q;
    if (wrAccept) begin
      wrCnt_d = wrCnt_q + AW'(1);
      if (wrDone) begin
        wrSel_d = !wrSel_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rdCnt_d    = rdCnt_q;
    rdSel_d    = rdSel_q;
    rdDone     = 1'b0;
    outValid_d = outValid_q;
    outFirst_d = outFirst_q;
    outLast_d  = outLast_q;
    upRe_d     = upRe_q;
    upIm_d     = upIm_q;
    lRe_d      = lRe_q;
    lIm_d      = lIm_q;

    case (state_q)
      S_IDLE: begin
        if (full_q[rdSel_q]) begin
          state_d = S_READ;
          rdCnt_d = '0;
        end
        if (outValid_q && out_ready) begin
          outValid_d = 1'b0;
          outFirst_d = 1'b0;
          outLast_d  = 1'b0;
        end
      end

      S_READ: begin
        if (rdLoad) begin
          upRe_d     = memRe_q[rdSel_q][rdAddrUp];
          upIm_d     = memIm_q[rdSel_q][rdAddrUp];
          lRe_d      = memRe_q[rdSel_q][rdAddrL];
          lIm_d      = memIm_q[rdSel_q][rdAddrL];
          outValid_d = 1'b1;
          outFirst_d = (rdCnt_q == '0);
          outLast_d  = (rdCnt_q == RD_LAST);
          rdCnt_d    = rdCnt_q + RW'(1);
          // Bank is fully captured once its last pair loads; chain straight into the other bank if ready.
          if (rdCnt_q == RD_LAST) begin
            rdDone  = 1'b1;
            rdSel_d = !rdSel_q;
            state_d = full_q[!rdSel_q] ? S_READ : S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A write completion always lands on a bank that is not being released, but let the set win anyway.
  always_comb begin
    full_d = full_q;
    if (rdDone) begin
      full_d[rdSel_q] = 1'b0;
    end
    if (wrDone) begin
      full_d[wrSel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wrSel_q    <= 1'b0;
      wrCnt_q    <= '0;
      rdSel_q    <= 1'b0;
      rdCnt_q    <= '0;
      state_q    <= S_IDLE;
      outValid_q <= 1'b0;
      outFirst_q <= 1'b0;
      outLast_q  <= 1'b0;
      upRe_q     <= '0;
      upIm_q     <= '0;
      lRe_q      <= '0;
      lIm_q      <= '0;
    end else begin
      full_q     <= full_d;
      wrSel_q    <= wrSel_d;
      wrCnt_q    <= wrCnt_d;
      rdSel_q    <= rdSel_d;
      rdCnt_q    <= rdCnt_d;
      state_q    <= state_d;
      outValid_q <= outValid_d;
      outFirst_q <= outFirst_d;
      outLast_q  <= outLast_d;
      upRe_q     <= upRe_d;
      upIm_q     <= upIm_d;
      lRe_q      <= lRe_d;
      lIm_q      <= lIm_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_first = outFirst_q;
  assign out_last  = outLast_q;
  assign outUp_re  = upRe_q;
  assign outUp_im  = upIm_q;
  assign outL_re   = lRe_q;
  assign outL_im   = lIm_q;

endmodule

// File: tb/tb_mdc_input_buffer.sv
// Bench for mdc_input_buffer: frame-level reference model (sample queue -> expected pairs) plus
// scenario tasks for latency, streaming, back-pressure, mid-read reset and bit-pattern extremes.
module tb_mdc_input_buffer;

  localparam int DATA_W = 9;
  localparam int N      = 32;
  localparam int HALF   = N / 2;

  typedef struct packed {
    logic [DATA_W-1:0] upRe;
    logic [DATA_W-1:0] upIm;
    logic [DATA_W-1:0] lRe;
    logic [DATA_W-1:0] lIm;
    logic              first;
    logic              last;
  } pair_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_re;
  logic [DATA_W-1:0] in_im;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] outUp_re;
  logic [DATA_W-1:0] outUp_im;
  logic [DATA_W-1:0] outL_re;
  logic [DATA_W-1:0] outL_im;
  logic              out_first;
  logic              out_last;

  always #5 clk = ~clk;

  mdc_input_buffer #(.DATA_W(DATA_W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .outUp_re (outUp_re),
    .outUp_im (outUp_im),
    .outL_re  (outL_re),
    .outL_im  (outL_im),
    .out_first(out_first),
    .out_last (out_last)
  );

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;

  // Reference model state: partial frame, expected pairs, observed transfers
  logic [2*DATA_W-1:0] frameBuf[$];
  pair_t               expQ[$];
  pair_t               gotQ[$];
  int                  gotCyc[$];
  int                  accepted    = 0;
  int                  transferred = 0;
  int                  holdErr     = 0;
  int                  readyErr    = 0;
  int                  readyLow    = 0;
  pair_t               prevOut;
  logic                prevHold    = 1'b0;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One clock cycle: observe at the falling edge, drive, update the model, advance to next falling edge.
  task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] re,
                               input logic [DATA_W-1:0] im, input logic ordy);
    pair_t               cur;
    int                  completed;
    int                  heldMax;
    int                  heldMin;
    logic [2*DATA_W-1:0] sUp;
    logic [2*DATA_W-1:0] sL;
    cur = {outUp_re, outUp_im, outL_re, outL_im, out_first, out_last};
    if (!rst) begin
      if (prevHold && (cur !== prevOut || out_valid !== 1'b1)) holdErr++;
      completed = accepted / N;
      heldMax   = completed - transferred / HALF;
      heldMin   = completed - (transferred + 1) / HALF;
      if (heldMax <= 1 && in_ready !== 1'b1) readyErr++;
      if (heldMin >= 2 && in_ready !== 1'b0) readyErr++;
      if (in_ready !== 1'b1) readyLow++;
    end
    in_valid  = iv;
    in_re     = re;
    in_im     = im;
    out_ready = ordy;
    if (rst) begin
      frameBuf.delete();
      expQ.delete();
      gotQ.delete();
      gotCyc.delete();
      accepted    = 0;
      transferred = 0;
      prevHold    = 1'b0;
    end else begin
      if (iv && in_ready === 1'b1) begin
        frameBuf.push_back({re, im});
        accepted++;
        if (frameBuf.size() == N) begin
          for (int k = 0; k < HALF; k++) begin
            sUp = frameBuf[k];
            sL  = frameBuf[k + HALF];
            expQ.push_back({sUp[2*DATA_W-1:DATA_W], sUp[DATA_W-1:0],
                            sL[2*DATA_W-1:DATA_W], sL[DATA_W-1:0],
                            (k == 0), (k == HALF - 1)});
          end
          frameBuf.delete();
        end
      end
      if (out_valid === 1'b1 && ordy) begin
        gotQ.push_back(cur);
        gotCyc.push_back(cycle);
        transferred++;
      end
      prevHold = (out_valid === 1'b1) && !ordy;
      prevOut  = cur;
    end
    @(posedge clk);
    cycle++;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 9'h155, 9'h0AA, 1'b1);
    applyStimulus(1'b1, 9'h155, 9'h0AA, 1'b1);
    rst = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    assertCount++;
    if ({out_first, out_last} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 00", {out_first, out_last}); end
    assertCount++;
    if ({outUp_re, outUp_im, outL_re, outL_im} !== '0) begin
      failCount++; $display("[TB] FAIL reset_data: got %h expected 0", {outUp_re, outUp_im, outL_re, outL_im});
    end
    assertCount++;
    if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    applyStimulus(1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_idle_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single_frame();
    doReset();
    for (int n = 0; n < N; n++) applyStimulus(1'b1, DATA_W'(n), DATA_W'(31 - n), 1'b1);
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL latency_e0: got %b expected 0", out_valid); end
    applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL latency_e1: got %b expected 0", out_valid); end
    applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL latency_e2: got %b expected 1", out_valid); end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (gotQ.size() !== HALF) begin failCount++; $display("[TB] FAIL single_count: got %0d expected %0d", gotQ.size(), HALF); end
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL single_valid_drop: got %b expected 0", out_valid); end
    for (int k = 0; k < HALF && k < gotQ.size(); k++) begin
      pair_t want;
      want = {DATA_W'(k), DATA_W'(31 - k), DATA_W'(k + 16), DATA_W'(15 - k), (k == 0), (k == HALF - 1)};
      assertCount++;
      if (gotQ[k] !== want) begin failCount++; $display("[TB] FAIL single_pair%0d: got %h expected %h", k, gotQ[k], want); end
      assertCount++;
      if (gotCyc[k] - gotCyc[0] !== k) begin
        failCount++; $display("[TB] FAIL single_consec%0d: got offset %0d expected %0d", k, gotCyc[k] - gotCyc[0], k);
      end
    end
  endtask

  task automatic test_continuous();
    doReset();
    readyLow = 0;
    for (int n = 0; n < 3 * N; n++) applyStimulus(1'b1, DATA_W'(n % 512), DATA_W'($urandom), 1'b1);
    assertCount++;
    if (readyLow !== 0) begin failCount++; $display("[TB] FAIL cont_in_ready: got %0d low cycles expected 0", readyLow); end
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (gotQ.size() !== 3 * HALF) begin failCount++; $display("[TB] FAIL cont_count: got %0d expected %0d", gotQ.size(), 3 * HALF); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (gotQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL cont_pair%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
      assertCount++;
      if (gotQ[i].upRe !== DATA_W'((i / HALF) * N + i % HALF) || gotQ[i].lRe !== DATA_W'((i / HALF) * N + i % HALF + HALF)) begin
        failCount++;
        $display("[TB] FAIL cont_index%0d: got %0d/%0d expected %0d/%0d", i, gotQ[i].upRe, gotQ[i].lRe,
                 (i / HALF) * N + i % HALF, (i / HALF) * N + i % HALF + HALF);
      end
      assertCount++;
      if (gotCyc[i] - gotCyc[i - i % HALF] !== i % HALF) begin
        failCount++; $display("[TB] FAIL cont_consec%0d: got offset %0d expected %0d", i, gotCyc[i] - gotCyc[i - i % HALF], i % HALF);
      end
    end
  endtask

  task automatic test_stall();
    doReset();
    readyLow = 0;
    for (int n = 0; n < 2 * N; n++) applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    assertCount++;
    if (readyLow !== 0) begin failCount++; $display("[TB] FAIL stall_fill_ready: got %0d low cycles expected 0", readyLow); end
    assertCount++;
    if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL stall_full: got %b expected 0", in_ready); end
    applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    assertCount++;
    if (accepted !== 2 * N) begin failCount++; $display("[TB] FAIL stall_extra_ignored: got %0d accepted expected %0d", accepted, 2 * N); end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    assertCount++;
    if ({out_valid, out_first, out_last} !== 3'b110) begin
      failCount++; $display("[TB] FAIL stall_hold_flags: got %b expected 110", {out_valid, out_first, out_last});
    end
    assertCount++;
    if (expQ.size() < 1 || {outUp_re, outUp_im, outL_re, outL_im} !== {expQ[0].upRe, expQ[0].upIm, expQ[0].lRe, expQ[0].lIm}) begin
      failCount++; $display("[TB] FAIL stall_hold_data: got %h expected pair 0 of frame 0", {outUp_re, outUp_im, outL_re, outL_im});
    end
    assertCount++;
    if (holdErr !== 0) begin failCount++; $display("[TB] FAIL stall_stable: got %0d changes expected 0", holdErr); end
    for (int i = 0; i < 40; i++) begin
      if (i <= 20) begin
        assertCount++;
        if (in_ready !== (i >= 15)) begin failCount++; $display("[TB] FAIL stall_drain_ready%0d: got %b expected %b", i, in_ready, (i >= 15)); end
      end
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    assertCount++;
    if (gotQ.size() !== 2 * HALF) begin failCount++; $display("[TB] FAIL stall_count: got %0d expected %0d", gotQ.size(), 2 * HALF); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (gotQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL stall_pair%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
      assertCount++;
      if (gotCyc[i] - gotCyc[0] !== i) begin failCount++; $display("[TB] FAIL stall_gap%0d: got offset %0d expected %0d", i, gotCyc[i] - gotCyc[0], i); end
    end
  endtask

  task automatic test_random();
    int guard;
    doReset();
    holdErr  = 0;
    readyErr = 0;
    guard    = 0;
    while (accepted < 4 * N && guard < 3000) begin
      applyStimulus(($urandom_range(0, 9) < 7), DATA_W'($urandom), DATA_W'($urandom), 1'($urandom));
      guard++;
    end
    guard = 0;
    while (gotQ.size() < 4 * HALF && guard < 1000) begin
      applyStimulus(1'b0, '0, '0, 1'($urandom));
      guard++;
    end
    assertCount++;
    if (gotQ.size() !== 4 * HALF || expQ.size() !== 4 * HALF) begin
      failCount++; $display("[TB] FAIL rand_count: got %0d pairs expected %0d (model %0d)", gotQ.size(), 4 * HALF, expQ.size());
    end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      assertCount++;
      if (gotQ[i] !== expQ[i]) begin failCount++; $display("[TB] FAIL rand_pair%0d: got %h expected %h", i, gotQ[i], expQ[i]); end
    end
    assertCount++;
    if (holdErr !== 0) begin failCount++; $display("[TB] FAIL rand_stable: got %0d changes expected 0", holdErr); end
    assertCount++;
    if (readyErr !== 0) begin failCount++; $display("[TB] FAIL rand_in_ready: got %0d violations expected 0", readyErr); end
  endtask

  task automatic test_reset_midread();
    int guard;
    doReset();
    for (int n = 0; n < N; n++) applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    for (int n = 0; n < HALF; n++) applyStimulus(1'b1, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    guard = 0;
    while (gotQ.size() < 7 && guard < 40) begin
      applyStimulus(1'b0, '0, '0, 1'b1);
      guard++;
    end
    assertCount++;
    if (gotQ.size() !== 7 || expQ.size() < 8 || outUp_re !== expQ[7].upRe) begin
      failCount++; $display("[TB] FAIL midread_pair7: got %0d pairs, upper re %h expected 7 pairs at pair 7", gotQ.size(), outUp_re);
    end
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1);
    rst = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midread_valid: got %b expected 0", out_valid); end
    assertCount++;
    if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL midread_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      assertCount++;
      if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midread_quiet%0d: got %b expected 0", i, out_valid); end
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    for (int n = 0; n < N; n++) applyStimulus(1'b1, DATA_W'(100 + n), DATA_W'(n), 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (gotQ.size() !== HALF) begin failCount++; $display("[TB] FAIL midread_count: got %0d expected %0d", gotQ.size(), HALF); end
    assertCount++;
    if (gotQ.size() < 1 || {gotQ[0].upRe, gotQ[0].lRe, gotQ[0].first} !== {9'd100, 9'd116, 1'b1}) begin
      failCount++; $display("[TB] FAIL midread_first: got %h expected upper 100 lower 116 first", (gotQ.size() > 0) ? gotQ[0] : '0);
    end
  endtask

  task automatic test_extremes();
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    doReset();
    a = 9'h100;
    b = 9'h0FF;
    for (int n = 0; n < N; n++) applyStimulus(1'b1, (n % 2) ? b : a, (n % 2) ? a : b, 1'b1);
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    assertCount++;
    if (gotQ.size() !== HALF) begin failCount++; $display("[TB] FAIL extreme_count: got %0d expected %0d", gotQ.size(), HALF); end
    for (int k = 0; k < HALF && k < gotQ.size(); k++) begin
      logic [4*DATA_W-1:0] want;
      want = (k % 2) ? {b, a, b, a} : {a, b, a, b};
      assertCount++;
      if ({gotQ[k].upRe, gotQ[k].upIm, gotQ[k].lRe, gotQ[k].lIm} !== want) begin
        failCount++; $display("[TB] FAIL extreme_pair%0d: got %h expected %h", k, {gotQ[k].upRe, gotQ[k].upIm, gotQ[k].lRe, gotQ[k].lIm}, want);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_continuous();
    test_stall();
    test_random();
    test_reset_midread();
    test_extremes();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mdc_input_buffer.md
Name: mdc_input_buffer

Overview:
- Input-side frame buffer for the 32-point MDC FFT. Mirror of the output reorder buffer.
- Accepts natural-order complex samples serially, one per cycle, into ping-pong banks.
- Emits each stored frame as 16 sample pairs on two lanes: upper x[k], lower x[k+16], k = 0..15.
- These pairs are the dual-path inputs of the first radix-2 butterfly stage.

Parameters:
DATA_W, 9, bit width of each real/imag component (passed through untouched, sign-agnostic)
N, 32, frame length in samples (power of 2); pairs per frame = N/2

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  sample present on in_re/in_im
in_ready  output  1  buffer can accept a sample this cycle
in_re  input  DATA_W  sample real part
in_im  input  DATA_W  sample imag part
out_ready  input  1  downstream accepts the current pair
out_valid  output  1  pair on output lanes is valid
outUp_re  output  DATA_W  upper lane real, x[k]
outUp_im  output  DATA_W  upper lane imag
outL_re  output  DATA_W  lower lane real, x[k+16]
outL_im  output  DATA_W  lower lane imag
out_first  output  1  high with pair k=0
out_last  output  1  high with pair k=N/2-1

Behaviour:
Storage and flags:
- Two banks, A and B, each N entries of re/im.
- Per-bank full flag: full[0] is A, full[1] is B.
- Write side: write_sel, wr_cnt (log2 N bits). Read side: rd_sel, rd_cnt (log2 N - 1 bits), state IDLE/READ.

Reset (synchronous, rst=1 at a rising edge):
- Clear all flags, counters, selects and outputs: out_valid=0, out_first=0, out_last=0, data outputs 0, state=IDLE.
- Bank contents are don't-care.
- Reset mid-frame or mid-read discards every partial or full frame. No pair is emitted afterwards until a new full frame has been written.

Write side:
- in_ready = !full[write_sel], combinational from registered flags.
- Write accepted when in_valid && in_ready: bank[write_sel][wr_cnt] <= sample, wr_cnt++.
- On the accept with wr_cnt==N-1: full[write_sel] <= 1, write_sel toggles, wr_cnt wraps to 0.
- in_valid while !in_ready: sample ignored, no state change.

Read side:
- IDLE: if full[rd_sel], go to READ on the next edge with rd_cnt=0. No output load on that edge.
- READ: load = !out_valid || out_ready. On a load edge:
  - outUp <= bank[rd_sel][rd_cnt]
  - outL <= bank[rd_sel][rd_cnt+N/2]
  - out_valid <= 1
  - out_first <= (rd_cnt==0)
  - out_last <= (rd_cnt==N/2-1)
  - rd_cnt++
- Load with rd_cnt==N/2-1:
  - full[rd_sel] <= 0 and rd_sel toggles. The bank's data is already captured in the output registers.
  - Stay in READ if full[~rd_sel] is already set (registered value), else go to IDLE.
- Not loading and out_valid && out_ready: out_valid, out_first, out_last <= 0.
- out_ready=0 with out_valid=1: all outputs and rd_cnt held stable.

Timing:
- Latency: sample N-1 accepted at edge E0 -> state READ after E1 -> pair 0 valid after E2 (out_ready=1).
- Back-to-back full banks: out_valid stays continuously high across the frame boundary. out_last of frame j is followed on the next cycle by out_first of frame j+1.
- Simultaneous release of full[rd_sel] and set of full[write_sel] on the same edge: both take effect. If write_sel equals the released bank, the set wins. This cannot occur because in_ready=0 while that bank is full.
- With out_ready held 1 and input at 1 sample/cycle, in_ready never deasserts.

Test Plan:
- Reset, then 32 samples re=n, im=31-n with in_valid=1 continuously, out_ready=1 -> out_valid rises 2 cycles after sample 31; pairs (re 0,16),(1,17)…(15,31), im (31,15)…(16,0); out_first only on pair 0, out_last only on pair 15; 16 consecutive valid cycles then out_valid=0.
- 96 continuous samples (3 frames, re=n mod 512) -> 48 pairs, frame j pair k gives upper re=32j+k, lower 32j+k+16; in_ready constantly 1.
- out_ready=0 from start, 64 samples -> pair 0 of frame 0 held stable on outputs; in_ready falls to 0 after sample 63 is accepted; a 65th sample with in_valid=1 is ignored. Raise out_ready -> frame 0 pairs drain, then in_ready returns to 1 in the cycle after the frame 0 out_last load; frame 1 follows with no gap.
- Random out_ready toggling (50%) during 4 frames -> every pair transferred exactly once, in order, with no duplicates or drops; outputs stable while out_valid && !out_ready.
- Assert rst at pair 7 of a read while the other bank is half-written -> next cycle out_valid=0 and in_ready=1; no output until a fresh 32 samples are written; the first pair after that is (0,16) of the new data.
- DATA_W=9 extremes: re=9'h100/9'h0FF alternating -> lanes carry identical bit patterns with no sign extension or truncation.
